// File: rtl/generic_mem_requester.sv
// Initiator front end for a single-port memory with one-cycle read latency:
// request channel in, memory drive out, read data returned in order through a credit-limited FIFO.
module generic_mem_requester #(
    parameter type T         = logic [31:0],
    parameter int  ADDR_W    = 8,
    parameter int  RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  T                  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output T                  rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output T                  mem_write_data,
    output logic              mem_write_en,
    input  T                  mem_read_data,
    output logic              idle
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inflight_q, inflight_d;
    T                 storage_q [RSP_DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic credit_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A read reserves a FIFO slot at issue; a same-cycle pop does not return credit early.
    always_comb begin
        credit_ok      = (count_q + CNT_W'(inflight_q)) < DEPTH_C;
        req_ready      = ~rst & (req_write | credit_ok);
        accept         = req_valid & req_ready;
        mem_addr       = req_addr;
        mem_write_data = req_wdata;
        mem_write_en   = accept & req_write;
        rsp_valid      = (count_q != '0);
        rsp_rdata      = storage_q[rd_ptr_q];
        idle           = ~inflight_q & (count_q == '0);
        push           = inflight_q;
        pop            = rsp_valid & rsp_ready;
        inflight_d     = accept & ~req_write;
        wr_ptr_d       = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d       = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d        = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // Storage needs no reset: an entry is only visible after it has been pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            storage_q[wr_ptr_q] <= mem_read_data;
        end
    end

endmodule
